// File: rtl/predecode_ir.sv
// Opcode predecode, instruction register and T-state counter for the 6502 core.
// PD samples the data latch every advancing cycle; IR loads on the fetch cycle or takes a forced BRK.
module predecode_ir #(
  parameter logic [7:0] RESET_OPCODE = 8'h00,
  parameter logic [2:0] T_MAX        = 3'd7
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic       i_rdy,
  input  logic [7:0] i_data,
  input  logic       i_last_cycle,
  input  logic       i_int_req,
  output logic [7:0] o_pd,
  output logic [7:0] o_ir,
  output logic [2:0] o_tstate,
  output logic       o_sync,
  output logic       o_pd_onebyte,
  output logic       o_ir_onebyte,
  output logic       o_forced_brk,
  output logic       o_pc_inc
);

  localparam logic [2:0] T_FETCH = 3'd1;
  localparam logic [2:0] T_FIRST = 3'd2;

  // Implied-operand opcodes: x8 always, xA except the immediate/zp-style x1A..x7A holes.
  function automatic logic is_onebyte(input logic [7:0] op);
    return (op[3:0] == 4'h8) ||
           ((op[3:0] == 4'hA) && (op[7] || !op[4]));
  endfunction

  logic adv;
  logic in_fetch;

  assign adv      = i_clk_en && i_rdy;
  assign in_fetch = (o_tstate == T_FETCH);

  // NOTE: every state register below is written with <= so all of them see the
  // pre-edge values of each other; blocking writes here would create ordering bugs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pd         <= 8'h00;
      o_ir         <= RESET_OPCODE;
      o_tstate     <= T_FIRST;
      o_ir_onebyte <= 1'b0;
      o_forced_brk <= 1'b1;
    end else if (adv) begin
      o_pd <= i_data;
      if (in_fetch) begin
        o_tstate <= T_FIRST;
        if (i_int_req) begin
          o_ir         <= RESET_OPCODE;
          o_forced_brk <= 1'b1;
          o_ir_onebyte <= 1'b0;
        end else begin
          o_ir         <= i_data;
          o_forced_brk <= 1'b0;
          o_ir_onebyte <= is_onebyte(i_data);
        end
      end else if (i_last_cycle) begin
        o_tstate <= T_FETCH;
      end else if (o_tstate < T_MAX) begin
        o_tstate <= o_tstate + 3'd1;
      end
    end
  end

  // Fetch-cycle PC increment is suppressed when BRK is being injected.
  assign o_sync       = in_fetch;
  assign o_pd_onebyte = is_onebyte(o_pd);
  assign o_pc_inc     = in_fetch && !i_int_req;

endmodule

// File: tb/tb_predecode_ir.sv
// Self-checking bench for predecode_ir: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the documented behaviour.
module tb_predecode_ir;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       rdy;
  logic [7:0] data;
  logic       last;
  logic       intr;
  logic [7:0] o_pd;
  logic [7:0] o_ir;
  logic [2:0] o_tstate;
  logic       o_sync;
  logic       o_pd_onebyte;
  logic       o_ir_onebyte;
  logic       o_forced_brk;
  logic       o_pc_inc;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int m_pd, m_ir, m_t;
  bit m_ob, m_brk;

  predecode_ir #(.RESET_OPCODE(8'h00), .T_MAX(3'd7)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_rdy(rdy), .i_data(data),
    .i_last_cycle(last), .i_int_req(intr),
    .o_pd(o_pd), .o_ir(o_ir), .o_tstate(o_tstate), .o_sync(o_sync),
    .o_pd_onebyte(o_pd_onebyte), .o_ir_onebyte(o_ir_onebyte),
    .o_forced_brk(o_forced_brk), .o_pc_inc(o_pc_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_onebyte(input int op);
    int lo, hi;
    lo = op % 16;
    hi = op / 16;
    return (lo == 8) || (lo == 10 && (hi >= 8 || (hi % 2) == 0));
  endfunction

  task automatic set_in(input bit r, input bit en, input bit rd, input int d, input bit l, input bit irq);
    rst = r; clk_en = en; rdy = rd; data = 8'(d); last = l; intr = irq;
  endtask

  // Advance the model with the current inputs, then let the DUT take the same edge.
  task automatic tick();
    if (rst) begin
      m_pd = 0; m_ir = 0; m_t = 2; m_ob = 0; m_brk = 1;
    end else if (clk_en && rdy) begin
      m_pd = int'(data);
      if (m_t == 1) begin
        m_t = 2;
        if (intr) begin m_ir = 0; m_brk = 1; m_ob = 0; end
        else begin m_ir = int'(data); m_brk = 0; m_ob = ref_onebyte(int'(data)); end
      end else if (last) m_t = 1;
      else if (m_t < 7) m_t = m_t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic goto_fetch();
    if (m_t != 1) begin
      set_in(0, 1, 1, $urandom_range(255), 1, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 8'hFF, 0, 0);
    tick();
    n_vec++; if (o_ir !== 8'h00) begin n_bad++; $display("FAIL reset_ir got %h exp 00", o_ir); end
    n_vec++; if (o_tstate !== 3'd2) begin n_bad++; $display("FAIL reset_tstate got %0d exp 2", o_tstate); end
    n_vec++; if (o_sync !== 1'b0) begin n_bad++; $display("FAIL reset_sync got %b exp 0", o_sync); end
    n_vec++; if (o_forced_brk !== 1'b1) begin n_bad++; $display("FAIL reset_brk got %b exp 1", o_forced_brk); end
    n_vec++; if (o_pd !== 8'h00) begin n_bad++; $display("FAIL reset_pd got %h exp 00", o_pd); end
    n_vec++; if (o_ir_onebyte !== 1'b0) begin n_bad++; $display("FAIL reset_ir_onebyte got %b exp 0", o_ir_onebyte); end
  endtask

  task automatic test_fetch();
    set_in(0, 1, 1, 8'h00, 1, 0);
    tick();
    set_in(0, 1, 1, 8'hA9, 0, 0);
    #1;
    n_vec++; if (o_sync !== 1'b1) begin n_bad++; $display("FAIL fetch_sync got %b exp 1", o_sync); end
    n_vec++; if (o_pc_inc !== 1'b1) begin n_bad++; $display("FAIL fetch_pc_inc got %b exp 1", o_pc_inc); end
    tick();
    n_vec++; if (o_ir !== 8'hA9) begin n_bad++; $display("FAIL fetch_ir got %h exp a9", o_ir); end
    n_vec++; if (o_tstate !== 3'd2) begin n_bad++; $display("FAIL fetch_tstate got %0d exp 2", o_tstate); end
    n_vec++; if (o_ir_onebyte !== 1'b0) begin n_bad++; $display("FAIL fetch_ir_onebyte got %b exp 0", o_ir_onebyte); end
    n_vec++; if (o_forced_brk !== 1'b0) begin n_bad++; $display("FAIL fetch_brk got %b exp 0", o_forced_brk); end
  endtask

  task automatic test_onebyte();
    int  ops [6] = '{8'hE8, 8'h1A, 8'h9A, 8'h3A, 8'hCA, 8'hA9};
    bit  exp [6] = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      goto_fetch();
      set_in(0, 1, 1, ops[i], 0, 0);
      tick();
      n_vec++; if (o_ir_onebyte !== exp[i]) begin n_bad++; $display("FAIL onebyte_ir op=%h got %b exp %b", ops[i], o_ir_onebyte, exp[i]); end
      n_vec++; if (o_pd_onebyte !== exp[i]) begin n_bad++; $display("FAIL onebyte_pd op=%h got %b exp %b", ops[i], o_pd_onebyte, exp[i]); end
    end
  endtask

  task automatic test_interrupt();
    goto_fetch();
    set_in(0, 1, 1, 8'h4C, 0, 1);
    #1;
    n_vec++; if (o_pc_inc !== 1'b0) begin n_bad++; $display("FAIL int_pc_inc got %b exp 0", o_pc_inc); end
    tick();
    n_vec++; if (o_ir !== 8'h00) begin n_bad++; $display("FAIL int_ir got %h exp 00", o_ir); end
    n_vec++; if (o_forced_brk !== 1'b1) begin n_bad++; $display("FAIL int_brk got %b exp 1", o_forced_brk); end
    // A normal opcode, then an interrupt request in T3 must be ignored.
    goto_fetch();
    set_in(0, 1, 1, 8'hEA, 0, 0);
    tick();
    set_in(0, 1, 1, 8'h11, 0, 0);
    tick();
    set_in(0, 1, 1, 8'h22, 0, 1);
    tick();
    n_vec++; if (o_ir !== 8'hEA) begin n_bad++; $display("FAIL int_t3_ir got %h exp ea", o_ir); end
    n_vec++; if (o_forced_brk !== 1'b0) begin n_bad++; $display("FAIL int_t3_brk got %b exp 0", o_forced_brk); end
    n_vec++; if (o_tstate !== 3'd4) begin n_bad++; $display("FAIL int_t3_tstate got %0d exp 4", o_tstate); end
  endtask

  task automatic test_stall();
    logic [7:0] ir0, pd0;
    goto_fetch();
    ir0 = o_ir;
    pd0 = o_pd;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, $urandom_range(255), $urandom_range(1), 0);
      tick();
      n_vec++; if (o_sync !== 1'b1) begin n_bad++; $display("FAIL stall_sync cyc=%0d got %b exp 1", i, o_sync); end
      n_vec++; if (o_ir !== ir0) begin n_bad++; $display("FAIL stall_ir cyc=%0d got %h exp %h", i, o_ir, ir0); end
      n_vec++; if (o_pd !== pd0) begin n_bad++; $display("FAIL stall_pd cyc=%0d got %h exp %h", i, o_pd, pd0); end
    end
    set_in(0, 1, 1, 8'h60, 0, 0);
    tick();
    n_vec++; if (o_ir !== 8'h60) begin n_bad++; $display("FAIL stall_release_ir got %h exp 60", o_ir); end
    n_vec++; if (o_tstate !== 3'd2) begin n_bad++; $display("FAIL stall_release_tstate got %0d exp 2", o_tstate); end
  endtask

  task automatic test_saturation();
    int exp_t;
    goto_fetch();
    set_in(0, 1, 1, 8'hAD, 0, 0);
    tick();
    exp_t = 2;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 1, $urandom_range(255), 0, $urandom_range(1));
      tick();
      exp_t = (exp_t < 7) ? exp_t + 1 : 7;
      n_vec++; if (o_tstate !== 3'(exp_t)) begin n_bad++; $display("FAIL sat_tstate cyc=%0d got %0d exp %0d", i, o_tstate, exp_t); end
    end
    n_vec++; if (o_tstate !== 3'd7) begin n_bad++; $display("FAIL sat_final got %0d exp 7", o_tstate); end
  endtask

  task automatic test_reset_mid();
    goto_fetch();
    set_in(0, 1, 1, 8'hBD, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 8'h55, 0, 0);
      tick();
    end
    n_vec++; if (o_tstate !== 3'd5) begin n_bad++; $display("FAIL rstmid_pre_tstate got %0d exp 5", o_tstate); end
    set_in(1, 1, 1, 8'h77, 1, 1);
    tick();
    n_vec++; if (o_tstate !== 3'd2) begin n_bad++; $display("FAIL rstmid_tstate got %0d exp 2", o_tstate); end
    n_vec++; if (o_ir !== 8'h00) begin n_bad++; $display("FAIL rstmid_ir got %h exp 00", o_ir); end
    n_vec++; if (o_forced_brk !== 1'b1) begin n_bad++; $display("FAIL rstmid_brk got %b exp 1", o_forced_brk); end
  endtask

  task automatic test_random();
    bit exp_pc;
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(39) == 0, $urandom_range(7) != 0, $urandom_range(5) != 0,
             $urandom_range(255), $urandom_range(3) == 0, $urandom_range(3) == 0);
      #1;
      exp_pc = (m_t == 1) && !intr;
      n_vec++; if (o_pc_inc !== exp_pc) begin n_bad++; $display("FAIL rnd_pc_inc cyc=%0d got %b exp %b", i, o_pc_inc, exp_pc); end
      tick();
      n_vec++; if (o_pd !== 8'(m_pd)) begin n_bad++; $display("FAIL rnd_pd cyc=%0d got %h exp %h", i, o_pd, 8'(m_pd)); end
      n_vec++; if (o_ir !== 8'(m_ir)) begin n_bad++; $display("FAIL rnd_ir cyc=%0d got %h exp %h", i, o_ir, 8'(m_ir)); end
      n_vec++; if (o_tstate !== 3'(m_t)) begin n_bad++; $display("FAIL rnd_tstate cyc=%0d got %0d exp %0d", i, o_tstate, m_t); end
      n_vec++; if (o_sync !== (m_t == 1)) begin n_bad++; $display("FAIL rnd_sync cyc=%0d got %b exp %b", i, o_sync, m_t == 1); end
      n_vec++; if (o_ir_onebyte !== m_ob) begin n_bad++; $display("FAIL rnd_ir_onebyte cyc=%0d got %b exp %b", i, o_ir_onebyte, m_ob); end
      n_vec++; if (o_forced_brk !== m_brk) begin n_bad++; $display("FAIL rnd_brk cyc=%0d got %b exp %b", i, o_forced_brk, m_brk); end
      n_vec++; if (o_pd_onebyte !== ref_onebyte(m_pd)) begin n_bad++; $display("FAIL rnd_pd_onebyte cyc=%0d got %b exp %b", i, o_pd_onebyte, ref_onebyte(m_pd)); end
    end
  endtask

  initial begin
    set_in(0, 1, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_fetch();
    test_onebyte();
    test_interrupt();
    test_stall();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
